// File: rtl/neuron_mac.sv
// neuron_mac: streaming Q4.12 dot product plus bias, rounded and saturated for the sigmoid stage
module neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 16,
    parameter int FRAC     = 12,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

    typedef enum logic [1:0] {ACCUM, FINAL, HOLD} state_t;

    state_t state, state_n;
    logic signed [ACC_W-1:0] acc, prod_ext, bias_ext, sum_s, rnd_pre, rnd;
    logic signed [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0] cnt;
    logic fire, last, hi, lo;

    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'($signed(bias));
    assign sum_s    = acc + (bias_ext <<< FRAC);
    assign rnd_pre  = sum_s + HALF;
    assign rnd      = rnd_pre >>> FRAC;
    assign hi       = rnd > MAXV;
    assign lo       = rnd < MINV;
    assign in_ready = state == ACCUM;
    assign fire     = in_valid && in_ready;
    assign last     = cnt == CNT_W'(N_INPUTS - 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_n;
    end

    // Next state: the last beat ends accumulation, FINAL lasts one cycle, HOLD waits for the consumer
    always_comb begin
        state_n = state;
        state_n = (state == ACCUM && fire && last) ? FINAL :
                  (state == FINAL)                 ? HOLD  :
                  (state == HOLD && out_ready)     ? ACCUM : state;
    end

    // Datapath: accumulate products, then round, clip and hold the result
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (fire) begin
                acc <= acc + prod_ext;
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (state == FINAL) begin
                acc       <= '0;
                out_data  <= hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : rnd[DATA_W-1:0];
                out_sat   <= hi || lo;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and randomized checks of neuron_mac against an arithmetic reference
module tb_neuron_mac;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [15:0] in_x = 0, in_w = 0, bias = 0;
    logic in_ready, out_valid, out_sat;
    logic [15:0] out_data;
    int checks = 0, failures = 0;
    logic [15:0] xs [8];
    logic [15:0] ws [8];

    neuron_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] b, output logic [15:0] d, output logic s);
        longint acc = 0, sm, r;
        for (int i = 0; i < 8; i++) acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        sm = acc + longint'($signed(b)) * 4096;
        r = (sm + 2048) >>> 12;
        if (r > 32767) begin d = 16'h7fff; s = 1; end
        else if (r < -32768) begin d = 16'h8000; s = 1; end
        else begin d = r[15:0]; s = 0; end
    endfunction

    task automatic do_result(input logic [15:0] b, input int gap, input int hold, input string tag);
        logic [15:0] ed;
        logic es;
        bias = b;
        model(b, ed, es);
        for (int i = 0; i < 8; i++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 0;
                step();
            end
            chk({tag, "_rdy"}, 16'(in_ready), 16'd1);
            in_valid = 1; in_x = xs[i]; in_w = ws[i];
            step();
        end
        in_valid = 0;
        chk({tag, "_final_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_final_rdy"}, 16'(in_ready), 16'd0);
        step();
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_sat"}, 16'(out_sat), 16'(es));
        for (int k = 0; k < hold; k++) begin
            step();
            chk({tag, "_hold_valid"}, 16'(out_valid), 16'd1);
            chk({tag, "_hold_data"}, out_data, ed);
            chk({tag, "_hold_rdy"}, 16'(in_ready), 16'd0);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        chk({tag, "_drop_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_drop_rdy"}, 16'(in_ready), 16'd1);
    endtask

    task automatic fill(input logic [15:0] x, input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin xs[i] = x; ws[i] = w; end
    endtask

    initial begin
        step(); step();
        rst = 0;
        chk("reset_valid", 16'(out_valid), 16'd0);
        chk("reset_data", out_data, 16'h0000);
        chk("reset_sat", 16'(out_sat), 16'd0);
        chk("reset_rdy", 16'(in_ready), 16'd1);

        fill(16'h1000, 16'h0800);
        do_result(16'h0000, 0, 0, "t1");
        chk("t1_const", out_data, 16'h4000);

        fill(16'h7000, 16'h7000);
        do_result(16'h0000, 0, 0, "t2pos");
        chk("t2pos_const", out_data, 16'h7fff);
        fill(16'h7000, 16'h9000);
        do_result(16'h0000, 0, 0, "t2neg");
        chk("t2neg_const", out_data, 16'h8000);

        fill(16'h0000, 16'h0000);
        xs[0] = 16'h0001; ws[0] = 16'h0800;
        do_result(16'h0000, 0, 0, "t3up");
        chk("t3up_const", out_data, 16'h0001);
        ws[0] = 16'hf800;
        do_result(16'h0000, 0, 0, "t3dn");
        chk("t3dn_const", out_data, 16'h0000);
        fill(16'h0000, 16'h0000);
        do_result(16'h1000, 0, 0, "t3bias");
        chk("t3bias_const", out_data, 16'h1000);

        fill(16'h1000, 16'h0800);
        do_result(16'h0000, 0, 5, "t4");

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) begin
                xs[i] = 16'($urandom);
                ws[i] = (n == 0) ? 16'($urandom) : 16'($signed(16'($urandom)) >>> (n + 2));
            end
            do_result(16'($urandom), 50, n, "t5");
        end

        fill(16'h1000, 16'h0800);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_x = 16'h7000; in_w = 16'h7000;
            step();
        end
        in_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("t6_rst_valid", 16'(out_valid), 16'd0);
        chk("t6_rst_data", out_data, 16'h0000);
        chk("t6_rst_rdy", 16'(in_ready), 16'd1);
        do_result(16'h0000, 0, 0, "t6");
        chk("t6_const", out_data, 16'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
